// File: rtl/detector_seq_pkg.sv
// Shared constants, state encoding and symbol-extraction helper for the
// parametrised code-sequence detector.
package detector_seq_pkg;

    localparam int CODE_W    = 4;
    localparam int PROG_W    = CODE_W - 1;
    localparam int MAX_SYM_W = 32;
    localparam int MAX_BUS_W = 7 * MAX_SYM_W;

    localparam logic [CODE_W-1:0] CODE_IDLE = 4'b0000;
    localparam logic [CODE_W-1:0] CODE_FAIL = 4'b1000;
    localparam logic [CODE_W-1:0] CODE_MISS = 4'b1001;
    localparam logic [CODE_W-1:0] CODE_LATE = 4'b1010;
    localparam logic [CODE_W-1:0] CODE_TOUT = 4'b1011;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PROG,
        S_FAIL,
        S_MISS,
        S_LATE,
        S_TOUT
    } state_e;

    // The bus is zero-extended to a fixed maximum width so one function serves every SYM_W.
    function automatic logic [MAX_SYM_W-1:0] seq_sym(input logic [MAX_BUS_W-1:0] bus,
                                                     input int k, input int symW);
        logic [MAX_SYM_W-1:0] mask;
        mask = {MAX_SYM_W{1'b1}} >> (MAX_SYM_W - symW);
        return MAX_SYM_W'(bus >> (k * symW)) & mask;
    endfunction

endpackage

// File: rtl/detector_seq_if.sv
// Symbol strobe, programmed sequence and status bus between the keypad
// decoder and the detector.
interface detector_seq_if #(
    parameter int SYM_W   = 7,
    parameter int SEQ_LEN = 5
);
    logic                     ctrl;
    logic [SYM_W-1:0]         entrada;
    logic [SEQ_LEN*SYM_W-1:0] padrao;
    logic                     clr;
    logic [3:0]               saida;
    logic                     ok;
    logic                     fim;

    modport master (output ctrl, entrada, padrao, clr, input saida, ok, fim);
    modport slave  (input ctrl, entrada, padrao, clr, output saida, ok, fim);
endinterface

// File: rtl/detector_seq_match.sv
// Combinational compare of the incoming symbol against every programmed
// sequence entry and the abort symbol.
module detector_seq_match
    import detector_seq_pkg::*;
#(
    parameter int               SYM_W     = 7,
    parameter int               SEQ_LEN   = 5,
    parameter logic [SYM_W-1:0] ABORT_SYM = 7'b0101001
) (
    input  logic [SYM_W-1:0]         entrada,
    input  logic [SEQ_LEN*SYM_W-1:0] padrao,
    input  logic [PROG_W-1:0]        prog,
    output logic                     anyHit,
    output logic [PROG_W-1:0]        firstIdx,
    output logic                     fwdHit,
    output logic                     bwdHit,
    output logic                     abortHit
);

    logic [MAX_BUS_W-1:0] padraoExt;
    logic [SYM_W-1:0]     symTab [SEQ_LEN];

    assign padraoExt = MAX_BUS_W'(padrao);

    for (genvar k = 0; k < SEQ_LEN; k++) begin : gSym
        assign symTab[k] = SYM_W'(seq_sym(padraoExt, k, SYM_W));
    end

    // Scanning from the top down leaves the lowest matching index in firstIdx.
    always_comb begin
        anyHit   = 1'b0;
        firstIdx = '0;
        fwdHit   = 1'b0;
        bwdHit   = 1'b0;
        for (int k = SEQ_LEN - 1; k >= 0; k--) begin
            if (symTab[k] == entrada) begin
                anyHit   = 1'b1;
                firstIdx = PROG_W'(k);
                if (int'(prog) == k) fwdHit = 1'b1;
                if (int'(prog) == k + 2) bwdHit = 1'b1;
            end
        end
    end

    assign abortHit = (entrada == ABORT_SYM);

endmodule

// File: rtl/detector_seq_param.sv
// Programmable code-sequence detector: forward/backward stepping, abort,
// early/late mismatch classes, inactivity timeout and terminal hold.
module detector_seq_param
    import detector_seq_pkg::*;
#(
    parameter int               SYM_W      = 7,
    parameter int               SEQ_LEN    = 5,
    parameter logic [SYM_W-1:0] ABORT_SYM  = 7'b0101001,
    parameter int               LATE_START = 3,
    parameter int               TMO_CYC    = 8
) (
    input logic            clk,
    input logic            res,
    detector_seq_if.slave  bus
);

    localparam int CNT_W = (TMO_CYC > 0) ? $clog2(TMO_CYC + 1) : 1;

    if (SEQ_LEN < 2 || SEQ_LEN > 7) begin : gBadSeqLen
        $error("detector_seq_param: SEQ_LEN must lie in 2..7");
    end
    if (LATE_START > SEQ_LEN) begin : gBadLateStart
        $error("detector_seq_param: LATE_START must not exceed SEQ_LEN");
    end
    if (SYM_W < 1 || SYM_W > MAX_SYM_W) begin : gBadSymW
        $error("detector_seq_param: SYM_W out of range");
    end

    state_e              state_q, state_d;
    logic [PROG_W-1:0]   prog_q, prog_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CODE_W-1:0]   saida_q, saida_d;
    logic                ok_q, ok_d;

    logic                anyHit, fwdHit, bwdHit, abortHit;
    logic [PROG_W-1:0]   firstIdx;

    detector_seq_match #(
        .SYM_W    (SYM_W),
        .SEQ_LEN  (SEQ_LEN),
        .ABORT_SYM(ABORT_SYM)
    ) uMatch (
        .entrada (bus.entrada),
        .padrao  (bus.padrao),
        .prog    (prog_q),
        .anyHit  (anyHit),
        .firstIdx(firstIdx),
        .fwdHit  (fwdHit),
        .bwdHit  (bwdHit),
        .abortHit(abortHit)
    );

    // The counter defaults to clear; it only survives an idle cycle spent in PROG.
    always_comb begin
        state_d = state_q;
        prog_d  = prog_q;
        cnt_d   = '0;
        if (bus.clr) begin
            state_d = S_IDLE;
            prog_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.ctrl && anyHit) begin
                        state_d = S_PROG;
                        prog_d  = firstIdx + 3'd1;
                    end
                end
                S_PROG: begin
                    if (bus.ctrl) begin
                        if (fwdHit) begin
                            prog_d = prog_q + 3'd1;
                        end else if (bwdHit) begin
                            prog_d = prog_q - 3'd1;
                        end else if (abortHit) begin
                            state_d = S_FAIL;
                            prog_d  = '0;
                        end else begin
                            state_d = (int'(prog_q) < LATE_START) ? S_MISS : S_LATE;
                            prog_d  = '0;
                        end
                    end else if (TMO_CYC > 0) begin
                        if (cnt_q == CNT_W'(TMO_CYC - 1)) begin
                            state_d = S_TOUT;
                            prog_d  = '0;
                        end else if (cnt_q != {CNT_W{1'b1}}) begin
                            cnt_d = cnt_q + 1'b1;
                        end else begin
                            cnt_d = cnt_q;
                        end
                    end
                end
                default: ;
            endcase
        end

        case (state_d)
            S_PROG:  saida_d = {1'b0, prog_d};
            S_FAIL:  saida_d = CODE_FAIL;
            S_MISS:  saida_d = CODE_MISS;
            S_LATE:  saida_d = CODE_LATE;
            S_TOUT:  saida_d = CODE_TOUT;
            default: saida_d = CODE_IDLE;
        endcase
        ok_d = (state_d == S_PROG) && (int'(prog_d) == SEQ_LEN);
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q <= S_IDLE;
            prog_q  <= '0;
            cnt_q   <= '0;
            saida_q <= CODE_IDLE;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            prog_q  <= prog_d;
            cnt_q   <= cnt_d;
            saida_q <= saida_d;
            ok_q    <= ok_d;
        end
    end

    assign bus.saida = saida_q;
    assign bus.ok    = ok_q;
    assign bus.fim   = saida_q[3];

endmodule

// File: tb/tb_detector_seq_param.sv
// Directed bench for detector_seq_param: sequence walk, stepping, abort,
// mismatch classes, timeout, async reset and duplicate-entry priority.
module tb_detector_seq_param;

    localparam logic [6:0] SEQ0 = 7'b0010000;
    localparam logic [6:0] SEQ1 = 7'b0100100;
    localparam logic [6:0] SEQ2 = 7'b0000010;
    localparam logic [6:0] SEQ3 = 7'b1000111;
    localparam logic [6:0] SEQ4 = 7'b0111010;
    localparam logic [6:0] ABRT = 7'b0101001;
    localparam logic [6:0] JUNK = 7'b1111111;

    logic clk;
    logic res;
    int   testsRun;
    int   failCount;
    logic [6:0] seqTab [5];

    detector_seq_if #(.SYM_W(7), .SEQ_LEN(5)) bus ();

    detector_seq_param #(
        .SYM_W     (7),
        .SEQ_LEN   (5),
        .ABORT_SYM (7'b0101001),
        .LATE_START(3),
        .TMO_CYC   (8)
    ) dut (
        .clk(clk),
        .res(res),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge with the given inputs, then sample 1 ns after the edge.
    task automatic applyStimulus(input logic c, input logic [6:0] sym, input logic cl);
        bus.ctrl    = c;
        bus.entrada = sym;
        bus.clr     = cl;
        @(posedge clk);
        #1;
        bus.ctrl = 1'b0;
        bus.clr  = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 7'd0, 1'b0);
    endtask

    task automatic test_reset();
        #3;
        testsRun++;
        if (bus.saida !== 4'b0000) begin
            failCount++;
            $display("[TB] FAIL reset_saida got=%b want=0000", bus.saida);
        end
        testsRun++;
        if (bus.ok !== 1'b0 || bus.fim !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reset_flags got ok=%b fim=%b want ok=0 fim=0", bus.ok, bus.fim);
        end
        @(negedge clk);
        res = 1'b1;
    endtask

    task automatic test_full_sequence();
        logic [3:0] want;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, seqTab[k], 1'b0);
            want = 4'(k + 1);
            testsRun++;
            if (bus.saida !== want || bus.ok !== (k == 4)) begin
                failCount++;
                $display("[TB] FAIL full_step%0d got saida=%b ok=%b want saida=%b ok=%b",
                         k, bus.saida, bus.ok, want, (k == 4));
            end
        end
        applyStimulus(1'b1, SEQ3, 1'b0);
        testsRun++;
        if (bus.saida !== 4'b0100 || bus.ok !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL full_back_from_top got saida=%b ok=%b want saida=0100 ok=0",
                     bus.saida, bus.ok);
        end
        applyStimulus(1'b0, 7'd0, 1'b1);
    endtask

    task automatic test_abort();
        applyStimulus(1'b1, SEQ0, 1'b0);
        applyStimulus(1'b1, SEQ1, 1'b0);
        applyStimulus(1'b1, SEQ0, 1'b0);
        testsRun++;
        if (bus.saida !== 4'b0001) begin
            failCount++;
            $display("[TB] FAIL abort_backstep got=%b want=0001", bus.saida);
        end
        applyStimulus(1'b1, ABRT, 1'b0);
        testsRun++;
        if (bus.saida !== 4'b1000 || bus.fim !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL abort_fail got saida=%b fim=%b want saida=1000 fim=1", bus.saida, bus.fim);
        end
        applyStimulus(1'b1, SEQ1, 1'b0);
        applyStimulus(1'b1, SEQ0, 1'b0);
        idleCycles(10);
        testsRun++;
        if (bus.saida !== 4'b1000) begin
            failCount++;
            $display("[TB] FAIL abort_hold got=%b want=1000", bus.saida);
        end
        applyStimulus(1'b0, 7'd0, 1'b1);
        testsRun++;
        if (bus.saida !== 4'b0000 || bus.fim !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL abort_clr got saida=%b fim=%b want saida=0000 fim=0", bus.saida, bus.fim);
        end
    endtask

    task automatic test_mismatch();
        applyStimulus(1'b1, SEQ0, 1'b0);
        applyStimulus(1'b1, JUNK, 1'b0);
        testsRun++;
        if (bus.saida !== 4'b1001) begin
            failCount++;
            $display("[TB] FAIL miss_p1 got=%b want=1001", bus.saida);
        end
        applyStimulus(1'b0, 7'd0, 1'b1);
        for (int k = 0; k < 2; k++) applyStimulus(1'b1, seqTab[k], 1'b0);
        applyStimulus(1'b1, JUNK, 1'b0);
        testsRun++;
        if (bus.saida !== 4'b1001) begin
            failCount++;
            $display("[TB] FAIL miss_p2 got=%b want=1001", bus.saida);
        end
        applyStimulus(1'b0, 7'd0, 1'b1);
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, seqTab[k], 1'b0);
        applyStimulus(1'b1, JUNK, 1'b0);
        testsRun++;
        if (bus.saida !== 4'b1010) begin
            failCount++;
            $display("[TB] FAIL late_p3 got=%b want=1010", bus.saida);
        end
        applyStimulus(1'b0, 7'd0, 1'b1);
        for (int k = 0; k < 4; k++) applyStimulus(1'b1, seqTab[k], 1'b0);
        testsRun++;
        if (bus.saida !== 4'b0100) begin
            failCount++;
            $display("[TB] FAIL late_setup got=%b want=0100", bus.saida);
        end
        applyStimulus(1'b1, JUNK, 1'b0);
        testsRun++;
        if (bus.saida !== 4'b1010 || bus.fim !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL late_p4 got saida=%b fim=%b want saida=1010 fim=1", bus.saida, bus.fim);
        end
        applyStimulus(1'b0, 7'd0, 1'b1);
    endtask

    task automatic test_timeout();
        idleCycles(20);
        testsRun++;
        if (bus.saida !== 4'b0000) begin
            failCount++;
            $display("[TB] FAIL tmo_idle got=%b want=0000", bus.saida);
        end
        applyStimulus(1'b1, SEQ0, 1'b0);
        applyStimulus(1'b1, SEQ1, 1'b0);
        idleCycles(7);
        testsRun++;
        if (bus.saida !== 4'b0010) begin
            failCount++;
            $display("[TB] FAIL tmo_7_idle got=%b want=0010", bus.saida);
        end
        applyStimulus(1'b1, SEQ2, 1'b0);
        testsRun++;
        if (bus.saida !== 4'b0011) begin
            failCount++;
            $display("[TB] FAIL tmo_strobe got=%b want=0011", bus.saida);
        end
        idleCycles(7);
        testsRun++;
        if (bus.saida !== 4'b0011) begin
            failCount++;
            $display("[TB] FAIL tmo_cleared got=%b want=0011", bus.saida);
        end
        idleCycles(1);
        testsRun++;
        if (bus.saida !== 4'b1011 || bus.fim !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL tmo_fire got saida=%b fim=%b want saida=1011 fim=1", bus.saida, bus.fim);
        end
        applyStimulus(1'b1, SEQ3, 1'b0);
        testsRun++;
        if (bus.saida !== 4'b1011) begin
            failCount++;
            $display("[TB] FAIL tmo_hold got=%b want=1011", bus.saida);
        end
        applyStimulus(1'b0, 7'd0, 1'b1);
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, seqTab[k], 1'b0);
        #2;
        res = 1'b0;
        #1;
        testsRun++;
        if (bus.saida !== 4'b0000 || bus.fim !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL async_reset got saida=%b fim=%b want saida=0000 fim=0", bus.saida, bus.fim);
        end
        #2;
        res = 1'b1;
        applyStimulus(1'b1, SEQ3, 1'b0);
        testsRun++;
        if (bus.saida !== 4'b0100) begin
            failCount++;
            $display("[TB] FAIL reset_then_enter got=%b want=0100", bus.saida);
        end
        applyStimulus(1'b0, 7'd0, 1'b1);
    endtask

    task automatic test_back_to_back();
        applyStimulus(1'b1, ABRT, 1'b0);
        testsRun++;
        if (bus.saida !== 4'b0000) begin
            failCount++;
            $display("[TB] FAIL idle_abort got=%b want=0000", bus.saida);
        end
        applyStimulus(1'b1, SEQ4, 1'b0);
        testsRun++;
        if (bus.saida !== 4'b0101 || bus.ok !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL idle_enter_last got saida=%b ok=%b want saida=0101 ok=1", bus.saida, bus.ok);
        end
        applyStimulus(1'b1, SEQ4, 1'b0);
        testsRun++;
        if (bus.saida !== 4'b1010) begin
            failCount++;
            $display("[TB] FAIL top_no_forward got=%b want=1010", bus.saida);
        end
        applyStimulus(1'b0, 7'd0, 1'b1);
    endtask

    task automatic test_duplicates();
        bus.padrao = {SEQ4, SEQ3, SEQ0, SEQ1, SEQ0};
        applyStimulus(1'b1, SEQ0, 1'b0);
        testsRun++;
        if (bus.saida !== 4'b0001) begin
            failCount++;
            $display("[TB] FAIL dup_lowest_idx got=%b want=0001", bus.saida);
        end
        applyStimulus(1'b1, SEQ1, 1'b0);
        applyStimulus(1'b1, SEQ0, 1'b0);
        testsRun++;
        if (bus.saida !== 4'b0011) begin
            failCount++;
            $display("[TB] FAIL dup_forward_wins got=%b want=0011", bus.saida);
        end
        applyStimulus(1'b1, SEQ3, 1'b1);
        testsRun++;
        if (bus.saida !== 4'b0000) begin
            failCount++;
            $display("[TB] FAIL clr_beats_strobe got=%b want=0000", bus.saida);
        end
        bus.padrao = {SEQ4, SEQ3, SEQ2, SEQ1, SEQ0};
    endtask

    initial begin
        testsRun    = 0;
        failCount   = 0;
        seqTab[0]   = SEQ0;
        seqTab[1]   = SEQ1;
        seqTab[2]   = SEQ2;
        seqTab[3]   = SEQ3;
        seqTab[4]   = SEQ4;
        res         = 1'b0;
        bus.ctrl    = 1'b0;
        bus.clr     = 1'b0;
        bus.entrada = 7'd0;
        bus.padrao  = {SEQ4, SEQ3, SEQ2, SEQ1, SEQ0};

        test_reset();
        test_full_sequence();
        test_abort();
        test_mismatch();
        test_timeout();
        test_async_reset();
        test_back_to_back();
        test_duplicates();

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
